// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencer.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package e_mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    // Division ops select the longer latency.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Ops that occupy the sequencer; the madd family only when built in.
    function automatic logic is_start_op(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) ||
             (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/e_mdu_ctrl_calc.sv
// Combinational arithmetic for the MDU: op/A/B/HI/LO -> 64-bit {HI,LO}.
// Divide by zero and non-arithmetic ops return the current {HI,LO} so the
// completion write leaves the architectural registers unchanged.
// Optional feature macro: MDU_MADD_EN.
module mdu_calc
    import e_mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res
);

    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic [31:0] squot_s;
    logic [31:0] srem_s;
    logic [31:0] uquot_s;
    logic [31:0] urem_s;

    assign sprod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod_s = {32'd0, a} * {32'd0, b};
    assign squot_s = $signed(a) / $signed(b);
    assign srem_s  = $signed(a) % $signed(b);
    assign uquot_s = a / b;
    assign urem_s  = a % b;

    // Select the 64-bit result for the requested operation.
    always_comb begin
        res = {hi, lo};
        case (op)
            MD_MULT:  res = sprod_s;
            MD_MULTU: res = uprod_s;
            MD_DIV: begin
                if (b != 32'd0) res = {srem_s, squot_s};
                else            res = {hi, lo};
            end
            MD_DIVU: begin
                if (b != 32'd0) res = {urem_s, uquot_s};
                else            res = {hi, lo};
            end
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + sprod_s;
            MD_MADDU: res = {hi, lo} + uprod_s;
            MD_MSUB:  res = {hi, lo} - sprod_s;
            MD_MSUBU: res = {hi, lo} - uprod_s;
`endif
            default:  res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl_chk.sv
// Simulation checks for the MDU: the hazard unit must keep new mult/div
// and MTHI/MTLO instructions out of E while an operation is in flight.
module e_mdu_ctrl_chk
    import e_mdu_ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset_n,
    input logic       busy,
    input logic       start,
    input logic       req,
    input logic [3:0] op
);

    a_no_start_in_run: assert property (@(posedge clk) disable iff (!reset_n)
        busy |-> !start);

    a_no_mt_in_run: assert property (@(posedge clk) disable iff (!reset_n)
        (busy && !req) |-> !((op == MD_MTHI) || (op == MD_MTLO)));

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs fixed-latency
// mult/div, and produces busy and the decode-stage stall request.
// Optional feature macro: MDU_MADD_EN (madd family, MULT_CYCLES latency).
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_Req,
    input  logic        D_MDUse,
    output logic        E_Busy,
    output logic        D_MDStall,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDOut
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      calc_res_s;
    logic             start_ok_s;

    mdu_calc u_calc (
        .op  (E_MDOp),
        .a   (E_A),
        .b   (E_B),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (calc_res_s)
    );

    // A flushed instruction never starts an operation.
    assign start_ok_s = E_Start & ~E_Req & is_start_op(E_MDOp);

    // Next-state, counter, staging and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    tmp_hi_d = calc_res_s[63:32];
                    tmp_lo_d = calc_res_s[31:0];
                    cnt_d    = is_div_op(E_MDOp) ? CNT_W'(DIV_CYCLES)
                                                 : CNT_W'(MULT_CYCLES);
                    state_d  = ST_RUN;
                end else if (!E_Req && (E_MDOp == MD_MTHI)) begin
                    hi_d = E_A;
                end else if (!E_Req && (E_MDOp == MD_MTLO)) begin
                    lo_d = E_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // An in-flight op belongs to a committed instruction; E_Req
                // does not cancel it.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Move-from read port, decoded straight from the E-stage op.
    always_comb begin
        case (E_MDOp)
            MD_MFHI: E_MDOut = hi_q;
            MD_MFLO: E_MDOut = lo_q;
            default: E_MDOut = 32'd0;
        endcase
    end

    assign E_Busy    = (state_q == ST_RUN);
    assign D_MDStall = D_MDUse & (E_Busy | E_Start);
    assign E_HI      = hi_q;
    assign E_LO      = lo_q;

    e_mdu_ctrl_chk u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .busy    (E_Busy),
        .start   (E_Start),
        .req     (E_Req),
        .op      (E_MDOp)
    );

endmodule
